adv_timer_clk_gate_ctrl: RTL

Per-timer clock-enable controller for the advanced timer. It drives the `en_i` input of the `tc_clk_gating` cell in front of each timer core. Clocks are held on while a timer is configured or busy, and each timer clock is gated off after a programmable idle hysteresis. A wake request re-enables a timer clock, and a settle delay follows before the timer is reported ready for register access.

---
 rtl/adv_timer_cg_pkg.sv | 22 ++
 rtl/adv_timer_clk_gate_ch.sv | 89 ++++++++
 rtl/adv_timer_clk_gate_ctrl.sv | 42 ++++
 3 files changed

// File: rtl/adv_timer_cg_pkg.sv
// Shared types and parameter limits for the advanced-timer clock-gate controller.
package adv_timer_cg_pkg;

  typedef enum logic [1:0] {
    CG_RUN   = 2'd0,
    CG_DRAIN = 2'd1,
    CG_OFF   = 2'd2,
    CG_WAKE  = 2'd3
  } cg_state_e;

  localparam int CG_CNT_W    = 8;
  localparam int CG_IDLE_MIN = 1;
  localparam int CG_IDLE_MAX = 255;
  localparam int CG_WAKE_MIN = 1;
  localparam int CG_WAKE_MAX = 15;

  function automatic bit cg_params_ok(input int idle_cycles, input int wake_cycles);
    return (idle_cycles >= CG_IDLE_MIN) && (idle_cycles <= CG_IDLE_MAX) &&
           (wake_cycles >= CG_WAKE_MIN) && (wake_cycles <= CG_WAKE_MAX);
  endfunction

endpackage

// File: rtl/adv_timer_clk_gate_ch.sv
// One timer channel: idle hysteresis before gating, settle delay after waking.
module adv_timer_clk_gate_ch
  import adv_timer_cg_pkg::*;
#(
  parameter int IDLE_CYCLES = 8,
  parameter int WAKE_CYCLES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic active_i,
  output logic clk_en_o,
  output logic ready_o,
  output logic off_o
);

  localparam bit ParamsOk = cg_params_ok(IDLE_CYCLES, WAKE_CYCLES);
  localparam logic [CG_CNT_W-1:0] IdleLoad = CG_CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CG_CNT_W-1:0] WakeLoad = CG_CNT_W'(WAKE_CYCLES - 1);

  if (!ParamsOk) begin : g_bad_params
    $error("adv_timer_clk_gate_ch: IDLE_CYCLES or WAKE_CYCLES out of range");
  end

  cg_state_e             state_q, state_d;
  logic [CG_CNT_W-1:0]   cnt_q, cnt_d;
  logic                  clk_en_q, ready_q, off_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      CG_RUN: begin
        if (!active_i) begin
          state_d = CG_DRAIN;
          cnt_d   = IdleLoad;
        end
      end
      CG_DRAIN: begin
        if (active_i) begin
          state_d = CG_RUN;
        end else if (cnt_q == '0) begin
          state_d = CG_OFF;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      CG_OFF: begin
        if (active_i) begin
          state_d = CG_WAKE;
          cnt_d   = WakeLoad;
        end
      end
      CG_WAKE: begin
        // A wake always completes, so activity is not sampled here.
        if (cnt_q == '0) begin
          state_d = CG_RUN;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = CG_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= CG_RUN;
      cnt_q    <= '0;
      clk_en_q <= 1'b1;
      ready_q  <= 1'b0;
      off_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      clk_en_q <= (state_d != CG_OFF);
      ready_q  <= (state_d == CG_RUN) || (state_d == CG_DRAIN);
      off_q    <= (state_d == CG_OFF);
    end
  end

  assign clk_en_o = clk_en_q;
  assign ready_o  = ready_q;
  assign off_o    = off_q;

endmodule

// File: rtl/adv_timer_clk_gate_ctrl.sv
// Per-timer clock-enable controller: one independent gate FSM per timer channel.
module adv_timer_clk_gate_ctrl
  import adv_timer_cg_pkg::*;
#(
  parameter int N_TIMERS    = 4,
  parameter int IDLE_CYCLES = 8,
  parameter int WAKE_CYCLES = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                force_on_i,
  input  logic [N_TIMERS-1:0] cfg_en_i,
  input  logic [N_TIMERS-1:0] busy_i,
  input  logic [N_TIMERS-1:0] wake_req_i,
  output logic [N_TIMERS-1:0] clk_en_o,
  output logic [N_TIMERS-1:0] ready_o,
  output logic                all_gated_o
);

  logic [N_TIMERS-1:0] active;
  logic [N_TIMERS-1:0] off_ch;

  assign active = cfg_en_i | busy_i | wake_req_i | {N_TIMERS{force_on_i}};

  for (genvar gi = 0; gi < N_TIMERS; gi++) begin : g_ch
    adv_timer_clk_gate_ch #(
      .IDLE_CYCLES (IDLE_CYCLES),
      .WAKE_CYCLES (WAKE_CYCLES)
    ) u_ch (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .active_i (active[gi]),
      .clk_en_o (clk_en_o[gi]),
      .ready_o  (ready_o[gi]),
      .off_o    (off_ch[gi])
    );
  end

  // AND of per-channel registered OFF flags; no extra latency versus clk_en_o.
  assign all_gated_o = &off_ch;

endmodule
